// File: rtl/e_mult_div_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers.
// Multi-cycle latency is modelled with a down-counter; Busy stalls the front end.
module e_mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [CW-1:0] cnt;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_wr;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        b_zero;

    // Signed divide works on magnitudes, then restores signs (truncate toward zero).
    always_comb begin
        prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u  = {32'b0, A} * {32'b0, B};
        b_zero  = (B == 32'b0);
        abs_a   = A[31] ? -A : A;
        abs_b   = B[31] ? -B : B;
        divisor = b_zero ? 32'd1 : abs_b;
        q_mag   = abs_a / divisor;
        r_mag   = abs_a % divisor;
        q_s     = (A[31] ^ B[31]) ? -q_mag : q_mag;
        r_s     = A[31] ? -r_mag : r_mag;
        q_u     = A / (b_zero ? 32'd1 : B);
        r_u     = A % (b_zero ? 32'd1 : B);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Busy   <= 1'b0;
            HI     <= 32'b0;
            LO     <= 32'b0;
            cnt    <= '0;
            res_hi <= 32'b0;
            res_lo <= 32'b0;
            res_wr <= 1'b0;
        end else if (Busy) begin
            if (cnt == '0) begin
                Busy <= 1'b0;
                if (res_wr) begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else if (Start) begin
            case (Op)
                OP_MULT: begin
                    {res_hi, res_lo} <= prod_s;
                    res_wr <= 1'b1;
                    cnt    <= CW'(MULT_CYCLES - 1);
                    Busy   <= 1'b1;
                end
                OP_MULTU: begin
                    {res_hi, res_lo} <= prod_u;
                    res_wr <= 1'b1;
                    cnt    <= CW'(MULT_CYCLES - 1);
                    Busy   <= 1'b1;
                end
                OP_DIV: begin
                    res_hi <= r_s;
                    res_lo <= q_s;
                    res_wr <= !b_zero;
                    cnt    <= CW'(DIV_CYCLES - 1);
                    Busy   <= 1'b1;
                end
                OP_DIVU: begin
                    res_hi <= r_u;
                    res_lo <= q_u;
                    res_wr <= !b_zero;
                    cnt    <= CW'(DIV_CYCLES - 1);
                    Busy   <= 1'b1;
                end
                OP_MTHI: HI <= A;
                OP_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mult_div_unit.sv
// Directed and random checks of e_mult_div_unit against an arithmetic model.
// Expected HI/LO come from plain 64-bit integer arithmetic on the operands.
module tb_e_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    e_mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd1: begin p = ua * ub; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                exp_lo = q[31:0]; exp_hi = r[31:0];
            end
            3'd3: if (b != 0) begin
                p = ua / ub; exp_lo = p[31:0];
                p = ua % ub; exp_hi = p[31:0];
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endfunction

    // Issue one op, scramble operands after accept, and check every busy cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int poke);
        logic [31:0] old_hi, old_lo;
        int n;
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        old_hi = exp_hi; old_lo = exp_lo;
        model(op, a, b);
        @(negedge Clk);
        Start = 1'b0; A = $urandom; B = $urandom; Op = 3'($urandom_range(0, 7));
        if (op > 3'd3) begin
            chk("busy_mt", 32'(Busy), 32'd0);
            chk("hi_mt", HI, exp_hi);
            chk("lo_mt", LO, exp_lo);
            return;
        end
        n = (op < 3'd2) ? 5 : 10;
        for (int i = 1; i <= n; i++) begin
            chk("busy_run", 32'(Busy), 32'd1);
            chk("hi_hold", HI, old_hi);
            chk("lo_hold", LO, old_lo);
            Start = (i == poke);
            if (i == poke) begin Op = 3'd3; A = 32'd100; B = 32'd7; end
            @(negedge Clk);
        end
        Start = 1'b0;
        chk("busy_done", 32'(Busy), 32'd0);
        chk("hi_done", HI, exp_hi);
        chk("lo_done", LO, exp_lo);
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (2) @(negedge Clk);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        Reset = 1'b1;

        run_op(3'd0, 32'hFFFFFFFD, 32'd4, 0);
        chk("t1_hi", HI, 32'hFFFFFFFF);
        chk("t1_lo", LO, 32'hFFFFFFF4);

        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 0);
        chk("t2u_hi", HI, 32'h00000001);
        chk("t2u_lo", LO, 32'hFFFFFFFE);
        run_op(3'd0, 32'hFFFFFFFF, 32'd2, 0);
        chk("t2s_hi", HI, 32'hFFFFFFFF);
        chk("t2s_lo", LO, 32'hFFFFFFFE);

        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
        chk("t3_lo", LO, 32'hFFFFFFFD);
        chk("t3_hi", HI, 32'hFFFFFFFF);
        run_op(3'd4, 32'h12345678, 32'd0, 0);
        run_op(3'd5, 32'h12345678, 32'd0, 0);
        run_op(3'd3, 32'd7, 32'd0, 0);
        chk("t3z_hi", HI, 32'h12345678);
        chk("t3z_lo", LO, 32'h12345678);

        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("ovf_lo", LO, 32'h80000000);
        chk("ovf_hi", HI, 32'h00000000);

        run_op(3'd0, 32'd3, 32'd5, 2);
        chk("t4_lo", LO, 32'd15);
        chk("t4_hi", HI, 32'd0);

        @(negedge Clk);
        Start = 1'b1; Op = 3'd4; A = 32'hAAAA0000;
        @(negedge Clk);
        Op = 3'd5; A = 32'h5555;
        chk("t5_busy0", 32'(Busy), 32'd0);
        @(negedge Clk);
        Start = 1'b0;
        exp_hi = 32'hAAAA0000; exp_lo = 32'h5555;
        chk("t5_busy1", 32'(Busy), 32'd0);
        chk("t5_hi", HI, 32'hAAAA0000);
        chk("t5_lo", LO, 32'h5555);

        run_op(3'd7, 32'hDEADBEEF, 32'd1, 0);
        run_op(3'd6, 32'hDEADBEEF, 32'd1, 0);

        @(negedge Clk);
        Start = 1'b1; Op = 3'd2; A = 32'd1000; B = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        chk("t6_busy", 32'(Busy), 32'd1);
        Reset = 1'b0; Start = 1'b1; Op = 3'd4; A = 32'hFFFF0000;
        @(negedge Clk);
        Reset = 1'b1; Start = 1'b0;
        exp_hi = '0; exp_lo = '0;
        chk("t6_busy0", 32'(Busy), 32'd0);
        chk("t6_hi", HI, 32'd0);
        chk("t6_lo", LO, 32'd0);
        repeat (10) begin
            @(negedge Clk);
            chk("t6_nowr_hi", HI, 32'd0);
            chk("t6_nowr_lo", LO, 32'd0);
            chk("t6_nowr_busy", 32'(Busy), 32'd0);
        end
        run_op(3'd0, 32'd6, 32'd7, 0);
        chk("t6_mult", LO, 32'd42);

        for (int k = 0; k < 24; k++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (k % 6 == 0) b = 32'd0;
            if (k % 5 == 1) b = 32'($urandom_range(1, 20));
            if (k % 7 == 3) a = -a;
            run_op(op, a, b, (k % 4 == 2) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
